// File: rtl/cla_pipe_addsub_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
// Combinational content only: no latency and no backpressure of its own.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Per-bit propagate/generate/carry-in record used inside a CLA group
    typedef struct packed {
        logic p;
        logic g;
        logic c;
    } pgc_t;

    function automatic int ngrp(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result beat bundle for cla_pipe_addsub; valid/ready on both sides.
// Wires only: no latency; backpressure is carried by in_ready/out_ready.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic             Cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op_sub, A, B, Cin, out_ready,
        input  in_ready, out_valid, Q, Cout, ovf, zero
    );

    modport slave (
        input  in_valid, op_sub, A, B, Cin, out_ready,
        output in_ready, out_valid, Q, Cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub_group.sv
// GROUP-bit carry-lookahead slice: sum, group carry-out and carry into the group MSB.
// Purely combinational: zero latency, no backpressure.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    pgc_t [GROUP-1:0] bit_r;
    logic [GROUP:0]   carry;
    logic             acc;
    logic             prod;

    always_comb begin
        bit_r  = '0;
        carry  = '0;
        acc    = 1'b0;
        prod   = 1'b0;
        sum_o  = '0;
        for (int i = 0; i < GROUP; i++) begin
            bit_r[i].p = a_i[i] ^ b_i[i];
            bit_r[i].g = a_i[i] & b_i[i];
        end
        // Each carry is a flat sum-of-products over the lower bits, not a ripple chain
        carry[0] = cin_i;
        for (int i = 0; i < GROUP; i++) begin
            acc  = bit_r[i].g;
            prod = bit_r[i].p;
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & bit_r[j].g);
                prod = prod & bit_r[j].p;
            end
            carry[i+1] = acc | (prod & cin_i);
        end
        for (int i = 0; i < GROUP; i++) begin
            bit_r[i].c = carry[i];
            sum_o[i]   = bit_r[i].p ^ bit_r[i].c;
        end
        cout_o = carry[GROUP];
        cmsb_o = carry[GROUP-1];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA add/sub resolving one GROUP-bit slice per stage; NGRP cycles accept-to-result.
// One beat/cycle; any stall (enable low or output held) freezes every stage and drops in_ready.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    cla_pipe_addsub_if.slave  bus
);

    localparam int NGRP = ngrp(WIDTH, GROUP);

    logic             advance;
    logic             vld_q  [NGRP];
    logic [WIDTH-1:0] a_q    [NGRP];
    logic [WIDTH-1:0] b_q    [NGRP];
    logic             c_q    [NGRP];
    logic [WIDTH-1:0] a_d    [NGRP];
    logic [WIDTH-1:0] b_d    [NGRP];
    logic [GROUP-1:0] grp_s  [NGRP];
    logic             grp_co [NGRP];
    logic             grp_cm [NGRP];
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             out_vld_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign advance      = enable & ~(out_vld_q & ~bus.out_ready);
    assign bus.in_ready = advance;

    // The group being resolved always sits in the low GROUP bits of a_q/b_q
    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i    (a_q[k][GROUP-1:0]),
            .b_i    (b_q[k][GROUP-1:0]),
            .cin_i  (c_q[k]),
            .sum_o  (grp_s[k]),
            .cout_o (grp_co[k]),
            .cmsb_o (grp_cm[k])
        );
    end

    // a_q rotates right by one group per stage with the new sum slice entering at the
    // top, so after the last stage it holds the aligned result with no separate de-skew
    if (NGRP > 1) begin : g_rot
        for (genvar k = 0; k < NGRP; k++) begin : g_shift
            assign a_d[k] = {grp_s[k], a_q[k][WIDTH-1:GROUP]};
            assign b_d[k] = {{GROUP{1'b0}}, b_q[k][WIDTH-1:GROUP]};
        end
        assign q_d = a_d[NGRP-1];
    end else begin : g_single
        assign q_d = grp_s[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NGRP; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            out_vld_q <= 1'b0;
            q_q       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
                a_q[0] <= bus.A;
                b_q[0] <= bus.B ^ {WIDTH{bus.op_sub}};
                c_q[0] <= (bus.op_sub == OP_SUB) ? 1'b1 : bus.Cin;
            end
            for (int k = 1; k < NGRP; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    a_q[k] <= a_d[k-1];
                    b_q[k] <= b_d[k-1];
                    c_q[k] <= grp_co[k-1];
                end
            end
            out_vld_q <= vld_q[NGRP-1];
            if (vld_q[NGRP-1]) begin
                q_q    <= q_d;
                cout_q <= grp_co[NGRP-1];
                ovf_q  <= grp_cm[NGRP-1] ^ grp_co[NGRP-1];
                zero_q <= (q_d == '0);
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.Q         = q_q;
    assign bus.Cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed/random bench for cla_pipe_addsub with a result scoreboard.
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int NGRP  = WIDTH / GROUP;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   pop_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   npop  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t             m;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        m.q    = full[WIDTH-1:0];
        m.cout = full[WIDTH];
        m.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (m.q[WIDTH-1] != a[WIDTH-1]);
        m.zero = (m.q == '0);
        return m;
    endfunction

    task automatic drive(input logic sub, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.op_sub   = sub;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
    endtask

    task automatic drive_rand();
        drive(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // Inputs are set just after a rising edge; sampling happens mid-cycle
    task automatic cycle(input bit use_exp = 1'b0, input exp_t e = '0);
        exp_t got;
        exp_t want;
        #1;
        if (bus.in_valid && bus.in_ready)
            sb.push_back(use_exp ? e : model(bus.A, bus.B, bus.Cin, bus.op_sub));
        if (bus.out_valid && bus.out_ready && enable) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                want = sb.pop_front();
                got  = '{q: bus.Q, cout: bus.Cout, ovf: bus.ovf, zero: bus.zero};
                check($sformatf("q[%0d]", npop),    32'(got.q),    32'(want.q));
                check($sformatf("cout[%0d]", npop), 32'(got.cout), 32'(want.cout));
                check($sformatf("ovf[%0d]", npop),  32'(got.ovf),  32'(want.ovf));
                check($sformatf("zero[%0d]", npop), 32'(got.zero), 32'(want.zero));
            end
            pop_cyc.push_back(cyc);
            npop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && guard < 40) begin
            cycle();
            guard++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int mark;
        int n0;
        int stale;

        bus.in_valid  = 1'b0;
        bus.op_sub    = OP_ADD;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q",         32'(bus.Q),         32'd0);
        check("rst_cout",      32'(bus.Cout),      32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_in_ready_dis", 32'(bus.in_ready), 32'd0);
        enable = 1'b1;
        #1;
        check("rst_in_ready_en", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Carry wraps to zero; also measures accept-to-valid latency
        bus.out_ready = 1'b1;
        drive(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        cycle(1'b1, exp_t'{q: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            cycle();
            lat++;
        end
        check("latency", 32'(lat), 32'(NGRP));
        drain("drain_add");

        drive(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        cycle(1'b1, exp_t'{q: 16'h7FFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
        drive(OP_SUB, 16'h0003, 16'h0005, 1'b1);
        cycle(1'b1, exp_t'{q: 16'hFFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        drive(OP_ADD, 16'h7FFF, 16'h0000, 1'b1);
        cycle(1'b1, exp_t'{q: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        drive(OP_SUB, 16'h1234, 16'h1234, 1'b0);
        cycle(1'b1, exp_t'{q: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        drain("drain_directed");

        // Back-to-back stream must come out one result per cycle
        mark = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            cycle();
        end
        drain("drain_stream");
        check("stream_count", 32'(pop_cyc.size() - mark), 32'd8);
        if (pop_cyc.size() - mark >= 8)
            check("stream_rate", 32'(pop_cyc[mark+7] - pop_cyc[mark]), 32'd7);

        // Fill the pipe against a stalled consumer, hold, then release
        bus.out_ready = 1'b0;
        n0  = sb.size();
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            drive_rand();
            cycle();
            lat++;
        end
        check("fill_depth", 32'(sb.size() - n0), 32'(NGRP + 1));
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            cycle();
            check($sformatf("stall_in_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("stall_valid[%0d]", i),    32'(bus.out_valid), 32'd1);
            if (sb.size() > 0)
                check($sformatf("stall_q[%0d]", i), 32'(bus.Q), 32'(sb[0].q));
        end
        check("stall_no_accept", 32'(sb.size() - n0), 32'(NGRP + 1));
        bus.out_ready = 1'b1;
        drain("drain_stall");

        // Freeze with enable low while results are pending
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            cycle();
        end
        enable = 1'b0;
        n0 = sb.size();
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
            check($sformatf("frz_in_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("frz_valid[%0d]", i),    32'(bus.out_valid), 32'd1);
            if (sb.size() > 0)
                check($sformatf("frz_q[%0d]", i), 32'(bus.Q), 32'(sb[0].q));
        end
        check("frz_no_accept", 32'(sb.size()), 32'(n0));
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        drain("drain_enable");

        // Reset with beats in flight discards them all
        bus.out_ready = 1'b0;
        drive(OP_ADD, 16'h1234, 16'h1111, 1'b0);
        cycle(1'b1, exp_t'{q: 16'h2345, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        drive(OP_ADD, 16'h0F0F, 16'h0101, 1'b0);
        cycle();
        drive(OP_SUB, 16'h4000, 16'h0001, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_q",     32'(bus.Q),         32'h2345);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q",     32'(bus.Q),         32'd0);
        check("mid_rst_cout",  32'(bus.Cout),      32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.out_valid)
                stale++;
        end
        check("no_stale_beat", 32'(stale), 32'd0);
        drive(OP_ADD, 16'h00FF, 16'h0001, 1'b0);
        cycle(1'b1, exp_t'{q: 16'h0100, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        drain("drain_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
